// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - start/busy/done handshake and operand/result bus of the serial adder
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  // Requester side: issues operands and start, watches status and results.
  modport master (
    output start, a_in, b_in, cin,
    input  busy, done, sum, cout, ovf
  );

  // Adder side.
  modport slave (
    input  start, a_in, b_in, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder, LSB first, one bit per clock
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_adder_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  // One-bit full-adder cell: a, b, c in; d = sum, e = carry out.
  logic fa_a, fa_b, fa_c, fa_d, fa_e;
  assign fa_a = a_sh_q[0];
  assign fa_b = b_sh_q[0];
  assign fa_c = carry_q;
  assign fa_d = fa_a ^ fa_b ^ fa_c;
  assign fa_e = (fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c);

  // Sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
  logic [WIDTH:0] acc_ext;
  assign acc_ext = {fa_d, acc_q};

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state: accept start in IDLE/DONE, shift one bit per RUN cycle, publish on the last bit.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_sh_d  = bus.a_in;
          b_sh_d  = bus.b_in;
          carry_d = bus.cin;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        carry_d = fa_e;
        acc_d   = acc_ext[WIDTH:1];
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        if (cnt_q == LAST) begin
          // carry_q here is the carry into the MSB, so overflow needs no extra register.
          cnt_d   = '0;
          state_d = DONE;
          sum_d   = acc_ext[WIDTH:1];
          cout_d  = fa_e;
          ovf_d   = carry_q ^ fa_e;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - randomized self-checking bench for serial_adder against an arithmetic model
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) bus ();
  serial_adder_if #(.WIDTH(1)) bus1 ();

  serial_adder #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  int errors = 0;
  int checks = 0;

  // Results the adder is expected to be holding right now.
  logic [7:0] hsum = 8'h00;
  logic       hcout = 1'b0;
  logic       hovf = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Golden model: plain integer addition, signed overflow from operand/result signs.
  task automatic model8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                        output logic [7:0] s, output logic co, output logic ov);
    logic [8:0] t;
    t  = {1'b0, a} + {1'b0, b} + {8'b0, ci};
    s  = t[7:0];
    co = t[8];
    ov = (a[7] == b[7]) && (s[7] != a[7]);
  endtask

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic ci);
    bus.start = 1'b1;
    bus.a_in  = a;
    bus.b_in  = b;
    bus.cin   = ci;
  endtask

  // Called at the negedge where start was raised; returns at the done-cycle negedge.
  task automatic complete(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic ci, input int inject);
    logic [7:0] es;
    logic ec, eo;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      bus.start = (k == inject);
      if (k == inject) begin
        bus.a_in = 8'hAA;
        bus.b_in = 8'h55;
      end
      check({tag, "/busy"}, 32'(bus.busy), 32'd1);
      check({tag, "/done_early"}, 32'(bus.done), 32'd0);
      check({tag, "/sum_hold"}, 32'(bus.sum), 32'(hsum));
      check({tag, "/cout_hold"}, 32'(bus.cout), 32'(hcout));
      check({tag, "/ovf_hold"}, 32'(bus.ovf), 32'(hovf));
    end
    @(negedge clk);
    bus.start = 1'b0;
    model8(a, b, ci, es, ec, eo);
    check({tag, "/done"}, 32'(bus.done), 32'd1);
    check({tag, "/busy_end"}, 32'(bus.busy), 32'd0);
    check({tag, "/sum"}, 32'(bus.sum), 32'(es));
    check({tag, "/cout"}, 32'(bus.cout), 32'(ec));
    check({tag, "/ovf"}, 32'(bus.ovf), 32'(eo));
    hsum  = es;
    hcout = ec;
    hovf  = eo;
  endtask

  task automatic idle_check(input string tag, input int n);
    repeat (n) begin
      @(negedge clk);
      check({tag, "/idle_busy"}, 32'(bus.busy), 32'd0);
      check({tag, "/idle_done"}, 32'(bus.done), 32'd0);
      check({tag, "/idle_sum"}, 32'(bus.sum), 32'(hsum));
    end
  endtask

  task automatic op(input string tag, input logic [7:0] a, input logic [7:0] b, input logic ci);
    issue(a, b, ci);
    complete(tag, a, b, ci, 0);
    idle_check(tag, 1);
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.a_in   = '0;
    bus.b_in   = '0;
    bus.cin    = 1'b0;
    bus1.start = 1'b0;
    bus1.a_in  = '0;
    bus1.b_in  = '0;
    bus1.cin   = 1'b0;

    repeat (2) @(negedge clk);
    check("rst/busy", 32'(bus.busy), 32'd0);
    check("rst/done", 32'(bus.done), 32'd0);
    check("rst/sum", 32'(bus.sum), 32'd0);
    check("rst/cout", 32'(bus.cout), 32'd0);
    check("rst/ovf", 32'(bus.ovf), 32'd0);
    rst_n = 1'b1;
    idle_check("post_rst", 1);

    op("basic", 8'h0F, 8'h01, 1'b0);
    op("carry1", 8'hFF, 8'h01, 1'b0);
    op("carry2", 8'hFF, 8'h00, 1'b1);
    op("ovf1", 8'h7F, 8'h01, 1'b0);
    op("ovf2", 8'h80, 8'h80, 1'b0);

    // Start pulsed while busy must be ignored, with no second done afterwards.
    issue(8'h03, 8'h04, 1'b0);
    complete("ignore", 8'h03, 8'h04, 1'b0, 3);
    check("ignore/sum7", 32'(bus.sum), 32'h07);
    idle_check("ignore_after", 10);

    // Back-to-back: new start in the done cycle goes straight to RUN.
    issue(8'h01, 8'h02, 1'b0);
    complete("b2b_first", 8'h01, 8'h02, 1'b0, 0);
    issue(8'h10, 8'h20, 1'b0);
    complete("b2b_second", 8'h10, 8'h20, 1'b0, 0);
    check("b2b/sum30", 32'(bus.sum), 32'h30);
    idle_check("b2b_after", 1);

    // Asynchronous reset mid-operation.
    issue(8'h55, 8'h22, 1'b1);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst/busy", 32'(bus.busy), 32'd0);
    check("midrst/done", 32'(bus.done), 32'd0);
    check("midrst/sum", 32'(bus.sum), 32'd0);
    check("midrst/cout", 32'(bus.cout), 32'd0);
    check("midrst/ovf", 32'(bus.ovf), 32'd0);
    hsum  = 8'h00;
    hcout = 1'b0;
    hovf  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle_check("midrst_after", 12);

    // Random regression, randomly mixing idle gaps and back-to-back starts.
    for (int n = 0; n < 1000; n++) begin
      logic [7:0] ra, rb;
      logic rc;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      issue(ra, rb, rc);
      complete("rand", ra, rb, rc, 0);
      if ($urandom_range(0, 1) == 1) idle_check("rand_gap", 1);
    end
    idle_check("rand_end", 1);

    // WIDTH = 1: one RUN cycle, done two cycles after start.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      logic [1:0] t;
      logic es, ov;
      v = 3'(i);
      t = {1'b0, v[2]} + {1'b0, v[1]} + {1'b0, v[0]};
      es = t[0];
      ov = (v[2] == v[1]) && (es != v[2]);
      @(negedge clk);
      bus1.start = 1'b1;
      bus1.a_in  = v[2];
      bus1.b_in  = v[1];
      bus1.cin   = v[0];
      @(negedge clk);
      bus1.start = 1'b0;
      check("w1/busy", 32'(bus1.busy), 32'd1);
      check("w1/done_early", 32'(bus1.done), 32'd0);
      @(negedge clk);
      check("w1/done", 32'(bus1.done), 32'd1);
      check("w1/sum", 32'(bus1.sum), 32'(es));
      check("w1/cout", 32'(bus1.cout), 32'(t[1]));
      check("w1/ovf", 32'(bus1.ovf), 32'(ov));
      @(negedge clk);
      check("w1/done_clear", 32'(bus1.done), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
